axi_wr: RTL
===========

// Module: axi_wr
// PURPOSE
//  Helper that gives user logic a simple start/status interface for writing a burst to an AXI-3 slave.
//  User presents address, burst attributes and a flat data vector, pulses enable, then polls status.
//  Drives AW, W and B channels of the FPGA-to-HPS (or any AXI-3) slave port; write counterpart of the read helper.
// PARAMETERS
//  AXI_WR_ID_WIDTH       8   width of awid/wid/bid/id
//  AXI_WR_ADDR_WIDTH     32  width of awaddr/addr
//  AXI_WR_BUS_WIDTH      32  data bus width in bits (multiple of 8)
//  AXI_WR_MAX_BURST_LEN  1   beats held in data vector, 1..16
// PORTS
//  clock       in   1                   system clock, all logic on rising edge
//  reset_n     in   1                   asynchronous active-low reset
//  enable      in   1                   start request, sampled only when status==0
//  id          in   ID_WIDTH            transaction ID -> awid, wid
//  addr        in   ADDR_WIDTH          start address -> awaddr
//  data        in   MAX_BURST_LEN*BUS   beat n at data[n*BUS +: BUS]
//  strb        in   BUS/8               byte strobes, applied to every beat
//  burst_len   in   4                   beats-1 (0..15) -> awlen
//  burst_size  in   3                   bytes/beat = 2^burst_size -> awsize
//  burst_type, lock, cache, prot, user  in  2,2,4,3,5  pass-through to aw*
//  status      out  2                   0 ready, 1 busy, 2 done ok, 3 done error
//  awid..awuser out  per AXI-3           combinational copies of the inputs above
//  awvalid     out  1 / awready in 1     address handshake
//  wid, wdata, wstrb, wlast  out  ID,BUS,BUS/8,1   write data beat
//  wvalid      out  1 / wready  in 1     data handshake
//  bid in ID_WIDTH, bresp in 2, bvalid in 1, bready out 1   write response
// BEHAVIOUR
//  Reset (async): awvalid=0, wvalid=0, bready=0, status=0, beat counter=0, flags cleared; in-flight burst abandoned.
//  Inputs (id, addr, data, strb, burst_*) must be held stable while status==1.
//  States: IDLE(status 0) -> XFER(status 1) -> RESP(status 1) -> DONE(status 2/3) -> IDLE.
//  IDLE: enable=1 at edge N -> awvalid=1, wvalid=1, beat=0, aw_done=0, status=1 from N+1.
//  XFER: awvalid drops on edge where awvalid&&awready (aw_done=1), independently of W channel.
//   wdata = data[beat*BUS +: BUS]; beats with index >= MAX_BURST_LEN drive wdata=0.
//   wlast = (beat==burst_len); wstrb=strb; wid=id.
//   wvalid&&wready: beat increments; if wlast, wvalid<=0 (w_done=1).
//   W may complete before AW; both must complete before leaving XFER.
//   valid signals never drop before their handshake (AXI rule).
//  RESP: entered when aw_done and w_done (including same edge as final handshake); bready=1.
//   bvalid&&bready: bready<=0; status<=3 if bresp>=SLVERR(2'b10) else 2. bid not checked.
//   bvalid before RESP is not accepted (bready low); slave holds it.
//  DONE: status 2/3 for exactly one cycle, then 0; enable in that cycle ignored.
//  enable while status!=0 ignored. beat counter 4-bit, no wrap beyond burst_len.
//  Min latency, always-ready slave, 1 beat: enable@0 -> valids@1 -> bready@2 -> bvalid@2 -> status=2@3, 0@4.
// TESTING
//  1 beat, awready/wready/bready-slave immediate, bresp=0, data=32'hDEADBEEF -> wdata DEADBEEF, wlast=1, status 1,1,2,0.
//  MAX=4, burst_len=3, wready toggling 1/0 -> beats 0..3 in order, wlast only on beat 3, exactly 4 W handshakes.
//  awready held low 10 cycles, W accepted first -> awvalid stays 1, bready only after AW handshake, status=2.
//  4-beat burst, bresp=2'b10 -> status=3 for one cycle then 0; second enable starts new burst from beat 0.
//  reset_n low mid-XFER (beat 2) -> awvalid/wvalid/bready/status 0 immediately; next enable restarts at beat 0.
//  enable held high throughout -> back-to-back bursts, each with one-cycle status 2 then one-cycle 0 before restart.

Source files
------------

// File: rtl/axi_wr_if.sv
// rtl/axi_wr_if.sv - AXI-3 write address, data and response channel bundle
interface axi_wr_if #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
) ();
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [4:0]              awuser;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [BUS_WIDTH-1:0]    wdata;
    logic [BUS_WIDTH/8-1:0]  wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_wr.sv
// rtl/axi_wr.sv - start/status helper that issues one AXI-3 write burst
module axi_wr #(
    parameter int AXI_WR_ID_WIDTH      = 8,
    parameter int AXI_WR_ADDR_WIDTH    = 32,
    parameter int AXI_WR_BUS_WIDTH     = 32,
    parameter int AXI_WR_MAX_BURST_LEN = 1
) (
    input  logic                                             clock,
    input  logic                                             reset_n,
    input  logic                                             enable,
    input  logic [AXI_WR_ID_WIDTH-1:0]                       id,
    input  logic [AXI_WR_ADDR_WIDTH-1:0]                     addr,
    input  logic [AXI_WR_MAX_BURST_LEN*AXI_WR_BUS_WIDTH-1:0] data,
    input  logic [AXI_WR_BUS_WIDTH/8-1:0]                    strb,
    input  logic [3:0]                                       burst_len,
    input  logic [2:0]                                       burst_size,
    input  logic [1:0]                                       burst_type,
    input  logic [1:0]                                       lock,
    input  logic [3:0]                                       cache,
    input  logic [2:0]                                       prot,
    input  logic [4:0]                                       user,
    output logic [1:0]                                       status,
    axi_wr_if.master                                         axi
);
    localparam int BUS = AXI_WR_BUS_WIDTH;
    localparam int MAX = AXI_WR_MAX_BURST_LEN;

    typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      beat;
    logic            aw_done;
    logic            w_done;
    logic            err;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic [BUS-1:0]  wdata_sel;

    // Attribute channels are straight copies of the held user inputs
    assign axi.awid    = id;
    assign axi.awaddr  = addr;
    assign axi.awlen   = burst_len;
    assign axi.awsize  = burst_size;
    assign axi.awburst = burst_type;
    assign axi.awlock  = lock;
    assign axi.awcache = cache;
    assign axi.awprot  = prot;
    assign axi.awuser  = user;
    assign axi.wid     = id;
    assign axi.wstrb   = strb;
    assign axi.wdata   = wdata_sel;
    assign axi.wlast   = (beat == burst_len);

    // Valids are decoded from registered state so they cannot drop before their handshake
    assign axi.awvalid = (state == XFER) && !aw_done;
    assign axi.wvalid  = (state == XFER) && !w_done;
    assign axi.bready  = (state == RESP);

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign b_hs  = axi.bvalid && axi.bready;

    // Select the current beat from the flat vector; beats past the stored depth send zero
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < MAX; i++) begin
            if (beat == 4'(i)) begin
                wdata_sel = data[i*BUS +: BUS];
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: XFER exits only once both AW and the last W beat have been accepted
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = XFER;
            XFER: if ((aw_done || aw_hs) && (w_done || (w_hs && axi.wlast))) state_next = RESP;
            RESP: if (b_hs) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter, channel completion flags and response error capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat    <= 4'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        beat    <= 4'd0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                XFER: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        if (axi.wlast) begin
                            w_done <= 1'b1;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        err <= axi.bresp[1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Status reflects the FSM; DONE reports ok or error for its single cycle
    always_comb begin
        status = 2'd0;
        case (state)
            IDLE:    status = 2'd0;
            XFER:    status = 2'd1;
            RESP:    status = 2'd1;
            DONE:    status = err ? 2'd3 : 2'd2;
            default: status = 2'd0;
        endcase
    end
endmodule
